// File: rtl/ps2_rx_core.sv
// ps2_rx_core: PS/2 device-to-host receiver with line filtering, frame decode and byte FIFO.
// Optional idle-frame timeout enabled by defining PS2_TIMEOUT_EN.
module ps2_rx_core #(
  parameter int FIFO_DEPTH  = 8,
  parameter int FILT_LEN    = 4,
  parameter int TIMEOUT_CYC = 20000
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic                          en_i,
  input  logic                          clr_i,
  input  logic                          ps2_clk_i,
  input  logic                          ps2_dat_i,
  output logic [7:0]                    dat_o,
  output logic                          valid_o,
  input  logic                          ready_i,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt_o,
  output logic                          par_err_o,
  output logic                          frm_err_o,
  output logic                          ovf_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int FW = $clog2(FILT_LEN + 1);
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
  logic [1:0]         clk_sync_q, dat_sync_q, raw, filt_q, filt_d;
  logic [1:0][FW-1:0] fcnt_q, fcnt_d;
  logic               fall_q, din, to_hit;
  state_t             st_q, st_d;
  logic [2:0]         bit_q, bit_d;
  logic [7:0]         sh_q, sh_d;
  logic               par_q, par_d, push, perr_d, ferr_d, perr_q, ferr_q;
  logic [7:0]         mem_q [FIFO_DEPTH];
  logic [AW-1:0]      wp_q, wp_d, rp_q, rp_d;
  logic [AW:0]        cnt_q, cnt_d;
  logic               ovf_q, ovf_d, pop, wr, full;
  assign raw = {dat_sync_q[1], clk_sync_q[1]};
  assign din = filt_q[1];
  // Two-flop synchronisers, idle-high like the bus
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      clk_sync_q <= 2'b11;
      dat_sync_q <= 2'b11;
    end else begin
      clk_sync_q <= {clk_sync_q[0], ps2_clk_i};
      dat_sync_q <= {dat_sync_q[0], ps2_dat_i};
    end
  // Filter: a level change is accepted after FILT_LEN consecutive differing samples
  always_comb
    for (int i = 0; i < 2; i++) begin
      fcnt_d[i] = (raw[i] != filt_q[i] && fcnt_q[i] != FW'(FILT_LEN - 1)) ? fcnt_q[i] + 1'b1 : '0;
      filt_d[i] = (raw[i] != filt_q[i] && fcnt_q[i] == FW'(FILT_LEN - 1)) ? raw[i] : filt_q[i];
    end
  // Filtered levels and the registered falling-edge strobe of the PS/2 clock
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      filt_q <= 2'b11;
      fcnt_q <= '0;
      fall_q <= 1'b0;
    end else begin
      filt_q <= filt_d;
      fcnt_q <= fcnt_d;
      fall_q <= filt_q[0] & ~filt_d[0];
    end
`ifdef PS2_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] to_q;
  // Watchdog: cleared on every fall, counts while a frame is in progress
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) to_q <= '0;
    else          to_q <= (fall_q || st_q == IDLE) ? '0 : to_q + 1'b1;
  assign to_hit = st_q != IDLE && !fall_q && to_q == TW'(TIMEOUT_CYC - 1);
`else
  assign to_hit = TIMEOUT_CYC < 0;
`endif
  // Frame decoder: advances only on the fall strobe; disable or clear aborts the frame
  always_comb begin
    st_d   = st_q;
    bit_d  = bit_q;
    sh_d   = sh_q;
    par_d  = par_q;
    push   = 1'b0;
    perr_d = 1'b0;
    ferr_d = 1'b0;
    if (fall_q)
      case (st_q)
        IDLE: if (!din) begin
          st_d  = DATA;
          bit_d = '0;
        end
        DATA: begin
          sh_d  = {din, sh_q[7:1]};
          bit_d = bit_q + 3'd1;
          st_d  = bit_q == 3'd7 ? PARITY : DATA;
        end
        PARITY: begin
          par_d = din;
          st_d  = STOP;
        end
        default: begin
          st_d   = IDLE;
          ferr_d = !din;
          perr_d = din & ~^{sh_q, par_q};
          push   = din & ^{sh_q, par_q};
        end
      endcase
    if (to_hit) begin
      st_d   = IDLE;
      ferr_d = 1'b1;
    end
    if (!en_i || clr_i) begin
      st_d   = IDLE;
      push   = 1'b0;
      perr_d = 1'b0;
      ferr_d = 1'b0;
    end
  end
  // Decoder state and registered error pulses
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      st_q   <= IDLE;
      bit_q  <= '0;
      sh_q   <= '0;
      par_q  <= 1'b0;
      perr_q <= 1'b0;
      ferr_q <= 1'b0;
    end else begin
      st_q   <= st_d;
      bit_q  <= bit_d;
      sh_q   <= sh_d;
      par_q  <= par_d;
      perr_q <= perr_d;
      ferr_q <= ferr_d;
    end
  assign valid_o = cnt_q != '0;
  assign full    = cnt_q == (AW + 1)'(FIFO_DEPTH);
  assign pop     = valid_o & ready_i;
  assign wr      = push & (!full | pop);
  // FIFO pointer/count/overflow next state; clear beats any same-cycle push or pop
  always_comb begin
    wp_d  = clr_i ? '0 : wp_q + AW'(wr);
    rp_d  = clr_i ? '0 : rp_q + AW'(pop);
    cnt_d = clr_i ? '0 : cnt_q + (AW + 1)'(wr) - (AW + 1)'(pop);
    ovf_d = clr_i ? 1'b0 : ovf_q | (push & full & !pop);
  end
  // FIFO control registers
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  // FIFO storage; contents are only observed while valid, so no reset needed
  always_ff @(posedge clk_i)
    if (wr) mem_q[wp_q] <= sh_q;
  assign dat_o      = valid_o ? mem_q[rp_q] : '0;
  assign fifo_cnt_o = cnt_q;
  assign par_err_o  = perr_q;
  assign frm_err_o  = ferr_q;
  assign ovf_o      = ovf_q;
endmodule
